// File: rtl/dsp_x_mux.sv
// X-operand mux of the DSP datapath: selects zero/M/P/A:B onto the 48-bit X bus.
// Ports: clk, rst_n, ce, in0..in3 sources, sel1 (X sel), sel2 (Y sel) -> out, illegal.
module dsp_x_mux #(
  parameter bit XREG       = 1'b1,
  parameter bit M_SIGN_EXT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce,
  input  logic [47:0] in0,
  input  logic [42:0] in1,
  input  logic [47:0] in2,
  input  logic [47:0] in3,
  input  logic [1:0]  sel1,
  input  logic [1:0]  sel2,
  output logic [47:0] out,
  output logic        illegal
);

  logic [47:0] m_ext;
  logic [47:0] nx_d;
  logic        ill_d;

  assign m_ext = M_SIGN_EXT ? {{5{in1[42]}}, in1}
                            : {5'b0, in1};

  // M may only drive X when Y also carries M; otherwise X is forced to zero.
  always_comb begin
    nx_d  = 48'h0;
    ill_d = 1'b0;
    unique case (sel1)
      2'b00: nx_d = in0;
      2'b01: begin
        if (sel2 == 2'b01) begin
          nx_d = m_ext;
        end else begin
          ill_d = 1'b1;
        end
      end
      2'b10: nx_d = in2;
      2'b11: nx_d = in3;
      default: nx_d = 48'h0;
    endcase
  end

  generate
    if (XREG) begin : g_reg
      logic [47:0] out_q;
      logic        ill_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_q <= 48'h0;
          ill_q <= 1'b0;
        end else if (ce) begin
          out_q <= nx_d;
          ill_q <= ill_d;
        end
      end

      assign out     = out_q;
      assign illegal = ill_q;
    end else begin : g_comb
      logic unused_ok;
      assign unused_ok = ^{clk, ce, rst_n};
      assign out       = nx_d;
      assign illegal   = ill_d;
    end
  endgenerate

endmodule

// File: tb/tb_dsp_x_mux.sv
// Scoreboard bench for dsp_x_mux (XREG=1, M_SIGN_EXT=1).
// Stimulus pushes expected {illegal,out}; monitor pops one per clock edge.
module tb_dsp_x_mux;

  logic        clk;
  logic        rst_n;
  logic        ce;
  logic [47:0] in0;
  logic [42:0] in1;
  logic [47:0] in2;
  logic [47:0] in3;
  logic [1:0]  sel1;
  logic [1:0]  sel2;
  logic [47:0] out;
  logic        illegal;

  int checks;
  int errors;

  logic [48:0] sb_q[$];
  logic [48:0] last_exp;

  dsp_x_mux #(
    .XREG       (1'b1),
    .M_SIGN_EXT (1'b1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ce      (ce),
    .in0     (in0),
    .in1     (in1),
    .in2     (in2),
    .in3     (in3),
    .sel1    (sel1),
    .sel2    (sel2),
    .out     (out),
    .illegal (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [48:0] ref_nx(
    input logic [1:0]  s1,
    input logic [1:0]  s2,
    input logic [47:0] a0,
    input logic [42:0] a1,
    input logic [47:0] a2,
    input logic [47:0] a3
  );
    logic [47:0] m;
    m = {{5{a1[42]}}, a1};
    case (s1)
      2'b00: return {1'b0, a0};
      2'b01: return (s2 == 2'b01) ? {1'b0, m} : {1'b1, 48'h0};
      2'b10: return {1'b0, a2};
      default: return {1'b0, a3};
    endcase
  endfunction

  task automatic check(input string nm, input logic [48:0] got,
                       input logic [48:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got ill=%b out=%h exp ill=%b out=%h",
               nm, got[48], got[47:0], exp[48], exp[47:0]);
    end
  endtask

  // Monitor: every edge the register may update; compare against queue head.
  int pop_n;
  initial begin
    pop_n = 0;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        logic [48:0] e;
        e = sb_q.pop_front();
        pop_n++;
        check($sformatf("sb#%0d", pop_n), {illegal, out}, e);
      end
    end
  end

  task automatic drive(
    input logic        r,
    input logic        c,
    input logic [47:0] a0,
    input logic [42:0] a1,
    input logic [47:0] a2,
    input logic [47:0] a3,
    input logic [1:0]  s1,
    input logic [1:0]  s2,
    input logic [48:0] exp
  );
    @(negedge clk);
    rst_n = r;
    ce    = c;
    in0   = a0;
    in1   = a1;
    in2   = a2;
    in3   = a3;
    sel1  = s1;
    sel2  = s2;
    sb_q.push_back(exp);
    last_exp = exp;
  endtask

  function automatic logic [47:0] r48();
    logic [63:0] v;
    v = {$urandom(), $urandom()};
    return v[47:0];
  endfunction

  function automatic logic [42:0] r43();
    logic [63:0] v;
    v = {$urandom(), $urandom()};
    return v[42:0];
  endfunction

  task automatic rnd(input int mode);
    logic [47:0] a0;
    logic [42:0] a1;
    logic [47:0] a2;
    logic [47:0] a3;
    logic [1:0]  s1;
    logic [1:0]  s2;
    logic        c;
    logic [48:0] e;
    a0 = r48();
    a1 = r43();
    a2 = r48();
    a3 = r48();
    s1 = 2'($urandom_range(0, 3));
    s2 = 2'($urandom_range(0, 3));
    c  = ($urandom_range(0, 7) != 0);
    case (mode)
      0: s1 = 2'b01;
      1: s1 = 2'b00;
      3: s2 = 2'b01;
      4: s2 = 2'b00;
      default: ;
    endcase
    e = c ? ref_nx(s1, s2, a0, a1, a2, a3) : last_exp;
    drive(1'b1, c, a0, a1, a2, a3, s1, s2, e);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    last_exp = 49'h0;
    rst_n = 1'b0;
    ce    = 1'b1;
    in0   = 48'h0;
    in1   = 43'h0;
    in2   = 48'h0;
    in3   = 48'h0;
    sel1  = 2'b00;
    sel2  = 2'b00;
    #1;
    check("reset_init", {illegal, out}, 49'h0);

    // Reset held with random inputs and ce=1.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, r48(), r43(), r48(), r48(),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 49'h0);
    end
    // First capture after release.
    drive(1'b1, 1'b1, 48'h0, 43'h0, 48'h1111_2222_3333, 48'h0,
          2'b10, 2'b00, {1'b0, 48'h1111_2222_3333});

    // M on X with M on Y: sign extension from bit 42.
    drive(1'b1, 1'b1, 48'h0, 43'h400_0000_0001, 48'h0, 48'h0,
          2'b01, 2'b01, {1'b0, 48'hFC00_0000_0001});
    drive(1'b1, 1'b1, 48'h0, 43'h0FF_FFFF_FFFF, 48'h0, 48'h0,
          2'b01, 2'b01, {1'b0, 48'h00FF_FFFF_FFFF});

    // Illegal combinations, then legal clears.
    drive(1'b1, 1'b1, 48'h0, 43'h123, 48'h0, 48'h0,
          2'b01, 2'b00, {1'b1, 48'h0});
    drive(1'b1, 1'b1, 48'h0, 43'h123, 48'h0, 48'h0,
          2'b01, 2'b10, {1'b1, 48'h0});
    drive(1'b1, 1'b1, 48'h0, 43'h123, 48'h0, 48'h0,
          2'b01, 2'b11, {1'b1, 48'h0});
    drive(1'b1, 1'b1, 48'h0, 43'h123, 48'h0, 48'h0,
          2'b01, 2'b01, {1'b0, 48'h0000_0000_0123});

    // P and A:B pass-through; sel2 irrelevant.
    drive(1'b1, 1'b1, 48'h0, 43'h7, 48'hA5A5_0000_FFFF, 48'h0,
          2'b10, 2'b11, {1'b0, 48'hA5A5_0000_FFFF});
    drive(1'b1, 1'b1, 48'h0, 43'h7, 48'hA5A5_0000_FFFF, 48'h0,
          2'b10, 2'b01, {1'b0, 48'hA5A5_0000_FFFF});
    drive(1'b1, 1'b1, 48'h0, 43'h7, 48'h0, 48'h0123_4567_89AB,
          2'b11, 2'b00, {1'b0, 48'h0123_4567_89AB});

    // Zero source with noisy other inputs.
    drive(1'b1, 1'b1, 48'h0, 43'h5A5_5A5A_5A5A, 48'hDEAD_BEEF_0000,
          48'hFFFF_FFFF_FFFF, 2'b00, 2'b01, 49'h0);
    drive(1'b1, 1'b1, 48'h0, 43'h0, 48'h0, 48'h0000_CAFE_0001,
          2'b11, 2'b00, {1'b0, 48'h0000_CAFE_0001});

    // ce=0 holds while inputs change.
    drive(1'b1, 1'b0, 48'h0, 43'h1, 48'h1234_5678_9ABC, 48'h0,
          2'b10, 2'b00, {1'b0, 48'h0000_CAFE_0001});
    drive(1'b1, 1'b0, 48'h0, 43'h1, 48'h0, 48'h0,
          2'b01, 2'b10, {1'b0, 48'h0000_CAFE_0001});
    drive(1'b1, 1'b1, 48'h0, 43'h1, 48'h0, 48'h0,
          2'b01, 2'b10, {1'b1, 48'h0});

    // Asynchronous reset mid-cycle discards the pending value.
    drive(1'b1, 1'b1, 48'h0, 43'h0, 48'h0, 48'hBBBB_CCCC_DDDD,
          2'b11, 2'b00, {1'b0, 48'hBBBB_CCCC_DDDD});
    @(negedge clk);
    in3 = 48'h7777_7777_7777;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", {illegal, out}, 49'h0);
    sb_q.push_back(49'h0);
    last_exp = 49'h0;
    drive(1'b1, 1'b1, 48'h0, 43'h0, 48'h0, 48'h7777_7777_7777,
          2'b11, 2'b00, {1'b0, 48'h7777_7777_7777});

    // Random classes.
    for (int m = 0; m < 5; m++) begin
      for (int i = 0; i < 500; i++) begin
        rnd(m);
      end
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
      @(posedge clk);
    end
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d exp 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
